// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared state encoding, error codes and default sync marker
// for the UART packet frame controller.
package uart_pkt_pkg;
    typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CSUM, DONE} pktState_t;
    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CSUM  = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;
    localparam logic [7:0] DEFAULT_SYNC = 8'h55;
endpackage

// File: rtl/uart_pkt_csum.sv
// uart_pkt_csum: 8-bit wrapping running sum with load/add and a check that
// the sum plus the current byte is zero modulo 256.
module uart_pkt_csum
    import uart_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic       add,
    input  logic [7:0] data,
    output logic       zero
);
    logic [7:0] sum;
    logic [7:0] total;

    assign total = sum + data;
    assign zero  = total == 8'd0;

    always_ff @(posedge clk) begin
        if (!reset_n)
            sum <= '0;
        else if (load)
            sum <= data;
        else if (add)
            sum <= total;
    end
endmodule

// File: rtl/uart_pkt_ctrl.sv
// uart_pkt_ctrl: frames SYNC/CMD/LEN/payload/checksum packets from the UART byte
// stream. Optional UART_PKT_STATS_EN adds saturating good/error frame counters.
module uart_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC,
    parameter int          MAX_LEN   = 64,
    parameter int          AW        = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    input  logic          rx_eop,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          pkt_valid,
    output logic [7:0]    pkt_cmd,
    output logic [7:0]    pkt_len,
    input  logic          pkt_ack,
    output logic          pkt_err,
    output logic [1:0]    err_code,
    output logic          busy
`ifdef UART_PKT_STATS_EN
    ,
    output logic [15:0]   good_cnt,
    output logic [15:0]   err_cnt
`endif
);
    localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

    pktState_t  state, stateNext;
    logic [7:0] cmdReg, lenReg, idx;
    logic       csLoad, csAdd, csZero, lenLoad, wrFire, pktLoad, errFire;
    logic [1:0] errNext;

    uart_pkt_csum uCsum (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (csLoad),
        .add     (csAdd),
        .data    (rx_data),
        .zero    (csZero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        csLoad    = 1'b0;
        csAdd     = 1'b0;
        lenLoad   = 1'b0;
        wrFire    = 1'b0;
        pktLoad   = 1'b0;
        errFire   = 1'b0;
        errNext   = ERR_NONE;
        case (state)
            IDLE:
                if (rx_ready && rx_data == SYNC_BYTE)
                    stateNext = CMD;
            CMD:
                if (rx_ready) begin
                    csLoad    = 1'b1;
                    stateNext = LEN;
                end
            LEN:
                if (rx_ready) begin
                    if (rx_data > MAX_LEN8) begin
                        errFire   = 1'b1;
                        errNext   = ERR_LEN;
                        stateNext = IDLE;
                    end else begin
                        csAdd     = 1'b1;
                        lenLoad   = 1'b1;
                        stateNext = rx_data == 8'd0 ? CSUM : PAYLOAD;
                    end
                end
            PAYLOAD:
                if (rx_ready) begin
                    csAdd     = 1'b1;
                    wrFire    = 1'b1;
                    stateNext = idx == lenReg - 8'd1 ? CSUM : PAYLOAD;
                end
            CSUM:
                if (rx_ready) begin
                    pktLoad   = csZero;
                    errFire   = !csZero;
                    errNext   = csZero ? ERR_NONE : ERR_CSUM;
                    stateNext = csZero ? DONE : IDLE;
                end
            DONE:
                // The ack takes priority over a colliding byte, which is simply dropped.
                if (pkt_ack)
                    stateNext = IDLE;
                else if (rx_ready) begin
                    errFire = 1'b1;
                    errNext = ERR_ABORT;
                end
            default:
                stateNext = IDLE;
        endcase
        // A line gap only aborts a frame when it does not coincide with a byte.
        if (!rx_ready && rx_eop && state inside {CMD, LEN, PAYLOAD, CSUM}) begin
            errFire   = 1'b1;
            errNext   = ERR_ABORT;
            stateNext = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmdReg   <= '0;
            lenReg   <= '0;
            idx      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            pkt_cmd  <= '0;
            pkt_len  <= '0;
            pkt_err  <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            wr_en   <= wrFire;
            pkt_err <= errFire;
            if (csLoad)
                cmdReg <= rx_data;
            if (lenLoad) begin
                lenReg <= rx_data;
                idx    <= '0;
            end else if (wrFire)
                idx <= idx + 8'd1;
            if (wrFire) begin
                wr_addr <= idx[AW-1:0];
                wr_data <= rx_data;
            end
            if (pktLoad) begin
                pkt_cmd <= cmdReg;
                pkt_len <= lenReg;
            end
            if (errFire)
                err_code <= errNext;
        end
    end

    assign pkt_valid = state == DONE;
    assign busy      = state != IDLE;

`ifdef UART_PKT_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            good_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (pktLoad && good_cnt != 16'hFFFF)
                good_cnt <= good_cnt + 16'd1;
            if (errFire && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif
endmodule
